// File: rtl/vmem_req_pkg.sv
// ---------------------------------------------------------------------------
// vmem_req_pkg
// Shared definitions for the vector memory requestor:
//   state_e      - requestor control states
//   MODE_*       - request address patterns as seen on req_mode
//   CMODE_*      - completer burst modes driven on mode_in
// ---------------------------------------------------------------------------
package vmem_req_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STORE,
        ST_LOAD,
        ST_GAP,
        ST_RESP
    } state_e;

    localparam logic [1:0] MODE_UNIT    = 2'b00;
    localparam logic [1:0] MODE_STRIDED = 2'b01;
    localparam logic [1:0] MODE_FIXED   = 2'b10;

    localparam logic [1:0] CMODE_INC    = 2'd1;
    localparam logic [1:0] CMODE_CONST  = 2'd0;

endpackage

// File: rtl/vmem_requestor_buffer.sv
// ---------------------------------------------------------------------------
// vreg_word_buffer
// One vector register worth of storage, organised as WORDS bus words.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset (clears contents)
//   clear_i          zero the whole register
//   load_i           parallel load of load_data_i
//   wr_en_i          write wr_data_i into word wr_idx_i
//   rd_idx_i         word selected onto rd_data_o
//   data_o           full register contents
// Priority: reset / clear, then parallel load, then word write.
// ---------------------------------------------------------------------------
module vreg_word_buffer
    import vmem_req_pkg::*;
#(
    parameter  int WORD_W = 32,
    parameter  int WORDS  = 8,
    localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1,
    localparam int BITS   = WORD_W * WORDS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [BITS-1:0]   load_data_i,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [WORD_W-1:0] wr_data_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [WORD_W-1:0] rd_data_o,
    output logic [BITS-1:0]   data_o
);

    logic [BITS-1:0] data_q;
    logic [BITS-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (clear_i) begin
            data_d = '0;
        end else if (load_i) begin
            data_d = load_data_i;
        end else if (wr_en_i) begin
            data_d[wr_idx_i*WORD_W +: WORD_W] = wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign rd_data_o = data_q[rd_idx_i*WORD_W +: WORD_W];
    assign data_o    = data_q;

endmodule

// File: rtl/vmem_requestor.sv
// ---------------------------------------------------------------------------
// vmem_requestor
// Turns one whole-register vector load/store into word-wide bursts on the
// vector memory completer's requestor interface. Unit-stride and fixed
// requests use one burst; strided requests use one single-beat burst per
// element with a one-cycle idle gap between them.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_*                         request handshake and fields from the lanes
//   resp_*                        completion handshake, store echo, load data
//   addr/length/mode_in           burst descriptor to the completer
//   wr/wrdata/ready               store beat channel
//   rd/rddataready/rddatavalid/rddata   load beat channel
// Optional: define VMEM_REQ_PERF_EN to add perf_stall_cycles, a saturating
// count of cycles where a beat was offered but not taken.
// ---------------------------------------------------------------------------
module vmem_requestor
    import vmem_req_pkg::*;
#(
    parameter  int ADDR_RANGE   = 32768,
    parameter  int LENGTH_RANGE = 32,
    parameter  int BUS_WIDTH    = 32,
    parameter  int VREG_BITS    = 256,
    localparam int ADDR_W       = $clog2(ADDR_RANGE),
    localparam int LEN_W        = $clog2(LENGTH_RANGE) + 1,
    localparam int WORDS        = VREG_BITS / BUS_WIDTH,
    localparam int IDX_W        = (WORDS > 1) ? $clog2(WORDS) : 1,
    localparam int BEAT_W       = $clog2(WORDS) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_store,
    input  logic [1:0]           req_mode,
    input  logic [ADDR_W-1:0]    req_base,
    input  logic [ADDR_W-1:0]    req_stride,
    input  logic [LEN_W-1:0]     req_len,
    input  logic [VREG_BITS-1:0] req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_store,
    output logic [VREG_BITS-1:0] resp_rdata,
    output logic [BUS_WIDTH-1:0] wrdata,
    output logic [ADDR_W-1:0]    addr,
    output logic [LEN_W-1:0]     length,
    output logic [1:0]           mode_in,
    output logic                 wr,
    output logic                 rd,
    output logic                 rddataready,
    input  logic                 ready,
    input  logic                 rddatavalid,
    input  logic [BUS_WIDTH-1:0] rddata
`ifdef VMEM_REQ_PERF_EN
    ,
    output logic [31:0]          perf_stall_cycles
`endif
);

    state_e               state_q, state_d;
    logic                 store_q, store_d;
    logic                 strided_q, strided_d;
    logic [1:0]           cmode_q, cmode_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [ADDR_W-1:0]    stride_q, stride_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;

    logic [LEN_W-1:0]     eff_len;
    logic                 beat_accept;
    logic                 last_beat;
    logic                 burst_active;
    logic                 buf_clear;
    logic                 buf_load;
    logic                 buf_wr_en;
    logic [BUS_WIDTH-1:0] buf_word;
    logic [VREG_BITS-1:0] buf_data;

    vreg_word_buffer #(
        .WORD_W (BUS_WIDTH),
        .WORDS  (WORDS)
    ) u_buffer (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (buf_clear),
        .load_i      (buf_load),
        .load_data_i (req_wdata),
        .wr_en_i     (buf_wr_en),
        .wr_idx_i    (beat_q[IDX_W-1:0]),
        .wr_data_i   (rddata),
        .rd_idx_i    (beat_q[IDX_W-1:0]),
        .rd_data_o   (buf_word),
        .data_o      (buf_data)
    );

    // Request length is clamped to what fits in one register and one burst.
    always_comb begin
        eff_len = req_len;
        if (int'(eff_len) > WORDS) begin
            eff_len = LEN_W'(WORDS);
        end
        if (int'(eff_len) > LENGTH_RANGE) begin
            eff_len = LEN_W'(LENGTH_RANGE);
        end
    end

    // Outputs decode from registered state only, so the completer never sees
    // a combinational path from its own ready/valid back to our requests.
    always_comb begin
        burst_active = (state_q == ST_STORE) || (state_q == ST_LOAD) || (state_q == ST_GAP);
        req_ready    = (state_q == ST_IDLE);
        wr           = (state_q == ST_STORE);
        rddataready  = (state_q == ST_LOAD);
        rd           = rddataready;
        wrdata       = wr ? buf_word : '0;
        addr         = burst_active ? addr_q : '0;
        length       = '0;
        if (burst_active) begin
            length = strided_q ? LEN_W'(1) : len_q;
        end
        mode_in      = burst_active ? cmode_q : CMODE_CONST;
        resp_valid   = (state_q == ST_RESP);
        resp_store   = resp_valid & store_q;
        resp_rdata   = (resp_valid && !store_q) ? buf_data : '0;
        beat_accept  = (wr & ready) | (rddataready & rddatavalid);
        last_beat    = (32'(beat_q) + 32'd1) == 32'(len_q);
        buf_wr_en    = rddataready & rddatavalid;
    end

    // Next-state logic: capture in IDLE, count beats in STORE/LOAD, step the
    // strided address on the way out of GAP, wait for the consumer in RESP.
    always_comb begin
        state_d   = state_q;
        store_d   = store_q;
        strided_d = strided_q;
        cmode_d   = cmode_q;
        addr_d    = addr_q;
        stride_d  = stride_q;
        len_d     = len_q;
        beat_d    = beat_q;
        buf_clear = 1'b0;
        buf_load  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    store_d   = req_store;
                    strided_d = (req_mode == MODE_STRIDED);
                    cmode_d   = ((req_mode == MODE_STRIDED) || (req_mode == MODE_FIXED))
                                ? CMODE_CONST : CMODE_INC;
                    addr_d    = req_base;
                    stride_d  = req_stride;
                    len_d     = eff_len;
                    beat_d    = '0;
                    buf_load  = req_store;
                    buf_clear = !req_store;
                    if (eff_len == '0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = req_store ? ST_STORE : ST_LOAD;
                    end
                end
            end
            ST_STORE, ST_LOAD: begin
                if (beat_accept) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat) begin
                        state_d = ST_RESP;
                    end else if (strided_q) begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                addr_d  = addr_q + stride_q;
                state_d = store_q ? ST_STORE : ST_LOAD;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            store_q   <= 1'b0;
            strided_q <= 1'b0;
            cmode_q   <= CMODE_CONST;
            addr_q    <= '0;
            stride_q  <= '0;
            len_q     <= '0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            store_q   <= store_d;
            strided_q <= strided_d;
            cmode_q   <= cmode_d;
            addr_q    <= addr_d;
            stride_q  <= stride_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
        end
    end

`ifdef VMEM_REQ_PERF_EN
    logic [31:0] perf_q, perf_d;
    logic        stall;

    // Saturating stall counter; only reset clears it.
    always_comb begin
        stall  = (wr & !ready) | (rddataready & !rddatavalid);
        perf_d = perf_q;
        if (stall && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_cycles = perf_q;
`endif

endmodule
